nfc_flash_target: RTL

//   Synthesisable NAND flash target (device side of the nfc flash pins) for FPGA prototyping and closed-loop nfc sims.

---
 rtl/nfc_flash_target.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nfc_flash_target.sv
`default_nettype none
// ============================================================================
// Module   : nfc_flash_target
// Brief    : Device side of the NAND flash pins. Decodes controller strobes and
//            answers status / ID / page-read, accepts page-program.
// Revision : 1.0 - initial release
// ============================================================================
module nfc_flash_target #(
    parameter int          PAGE_BYTES = 64,
    parameter int          COL_CYC    = 2,
    parameter int          ROW_CYC    = 3,
    parameter int          T_RD       = 40,
    parameter int          T_PROG     = 100,
    parameter int          T_RST      = 20,
    parameter logic [39:0] ID_WORD    = 40'hEC_D3_51_95_58
) (
    input  logic       nfc_clk,
    input  logic       rstb_nfc,
    input  logic       nf_ceb_i,
    input  logic       nf_cle_i,
    input  logic       nf_ale_i,
    input  logic       nf_web_i,
    input  logic       nf_reb_i,
    input  logic       nf_wpb_i,
    input  logic [7:0] nf_dat_i,
    output logic [7:0] dev_dat_o,
    output logic       dev_dat_oe,
    output logic       nf_rnb_o
);

    localparam int c_aw   = $clog2(PAGE_BYTES);
    localparam int c_acyc = COL_CYC + ROW_CYC;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_WAIT_CONF = 3'd2,
        S_DIN       = 3'd3,
        S_BUSY      = 3'd4,
        S_DOUT      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_STATUS = 2'd0,
        SEL_ID     = 2'd1,
        SEL_PAGE   = 2'd2
    } sel_t;

    typedef enum logic [1:0] {
        OP_ID   = 2'd0,
        OP_READ = 2'd1,
        OP_PROG = 2'd2,
        OP_RST  = 2'd3
    } op_t;

    state_t            r_state;
    sel_t              r_sel;
    op_t               r_op;
    logic              r_web_q;
    logic              r_reb_q;
    logic [7:0]        r_dat_q;
    logic              r_wev;
    logic              r_wcle;
    logic              r_wale;
    logic [7:0]        r_wbyte;
    logic              r_rev;
    logic [3:0]        r_acnt;
    logic [c_aw-1:0]   r_col_ptr;
    logic [2:0]        r_id_ptr;
    logic [15:0]       r_cnt;
    logic              r_rnb;
    logic              r_fail;
    logic              r_stat_rd;
    logic              r_oe;
    logic [7:0]        r_dout;
    logic [7:0]        r_buf   [PAGE_BYTES];
    logic [7:0]        r_stage [PAGE_BYTES];
    logic [PAGE_BYTES-1:0] r_mask;

    logic              w_web_edge;
    logic              w_reb_edge;
    logic              w_cmd;
    logic              w_addr;
    logic              w_data;
    logic              w_busy_cont;
    logic              w_out_mode;
    logic [c_aw-1:0]   w_col_new;
    logic [7:0]        w_id_byte;
    logic [7:0]        w_dout;

    assign w_web_edge  = !nf_ceb_i && !r_web_q && nf_web_i;
    assign w_reb_edge  = !nf_ceb_i && !r_reb_q && nf_reb_i;
    assign w_cmd       = r_wev && r_wcle && !r_wale;
    assign w_addr      = r_wev && !r_wcle && r_wale;
    assign w_data      = r_wev && !r_wcle && !r_wale;
    assign w_busy_cont = (r_state == S_BUSY) && (r_cnt != '0);
    assign w_out_mode  = (r_state == S_DOUT) || ((r_state == S_BUSY) && r_stat_rd);

    // Column bytes arrive little-endian; splice the current byte into the pointer.
    // Row bytes are only counted: there is a single page, so they select nothing.
    always_comb begin
        w_col_new = r_col_ptr;
        for (int j = 0; j < c_aw; j++) begin
            if (int'(r_acnt) < COL_CYC && (j / 8) == int'(r_acnt)) begin
                w_col_new[j] = r_wbyte[j % 8];
            end
        end
    end

    always_comb begin
        case (r_id_ptr)
            3'd0:    w_id_byte = ID_WORD[39:32];
            3'd1:    w_id_byte = ID_WORD[31:24];
            3'd2:    w_id_byte = ID_WORD[23:16];
            3'd3:    w_id_byte = ID_WORD[15:8];
            default: w_id_byte = ID_WORD[7:0];
        endcase
    end

    always_comb begin
        case (r_sel)
            SEL_ID:   w_dout = w_id_byte;
            SEL_PAGE: w_dout = r_buf[r_col_ptr];
            default:  w_dout = {nf_wpb_i, r_rnb, 5'b0, r_fail};
        endcase
    end

    always_ff @(posedge nfc_clk) begin
        if (!rstb_nfc) begin
            r_state   <= S_IDLE;
            r_sel     <= SEL_STATUS;
            r_op      <= OP_ID;
            r_web_q   <= 1'b1;
            r_reb_q   <= 1'b1;
            r_dat_q   <= 8'h00;
            r_wev     <= 1'b0;
            r_wcle    <= 1'b0;
            r_wale    <= 1'b0;
            r_wbyte   <= 8'h00;
            r_rev     <= 1'b0;
            r_acnt    <= '0;
            r_col_ptr <= '0;
            r_id_ptr  <= '0;
            r_cnt     <= '0;
            r_rnb     <= 1'b1;
            r_fail    <= 1'b0;
            r_stat_rd <= 1'b0;
            r_oe      <= 1'b0;
            r_dout    <= 8'h00;
            r_mask    <= '0;
            for (int i = 0; i < PAGE_BYTES; i++) begin
                r_buf[i]   <= 8'(i);
                r_stage[i] <= 8'h00;
            end
        end else begin
            r_web_q <= nf_web_i;
            r_reb_q <= nf_reb_i;
            r_dat_q <= nf_dat_i;
            r_wev   <= w_web_edge;
            r_wcle  <= nf_cle_i;
            r_wale  <= nf_ale_i;
            r_wbyte <= r_dat_q;
            r_rev   <= w_reb_edge;
            r_oe    <= !nf_ceb_i && !nf_reb_i && w_out_mode;
            if (w_out_mode) begin
                r_dout <= w_dout;
            end

            if (r_state == S_BUSY) begin
                if (r_cnt == '0) begin
                    r_rnb     <= 1'b1;
                    r_stat_rd <= 1'b0;
                    case (r_op)
                        OP_PROG: begin
                            for (int i = 0; i < PAGE_BYTES; i++) begin
                                if (r_mask[i]) begin
                                    r_buf[i] <= r_stage[i];
                                end
                            end
                            r_mask  <= '0;
                            r_state <= S_IDLE;
                        end
                        OP_READ: begin
                            r_sel   <= SEL_PAGE;
                            r_state <= S_DOUT;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
            end

            if (w_cmd) begin
                if (r_wbyte == 8'hFF) begin
                    r_state   <= S_BUSY;
                    r_op      <= OP_RST;
                    r_cnt     <= 16'(T_RST - 1);
                    r_rnb     <= 1'b0;
                    r_fail    <= 1'b0;
                    r_mask    <= '0;
                    r_stat_rd <= 1'b0;
                end else if (r_wbyte == 8'h70) begin
                    r_sel <= SEL_STATUS;
                    if (w_busy_cont) begin
                        r_stat_rd <= 1'b1;
                    end else begin
                        r_state <= S_DOUT;
                    end
                end else if (!w_busy_cont) begin
                    case (r_wbyte)
                        8'h90: begin
                            r_op    <= OP_ID;
                            r_acnt  <= '0;
                            r_state <= S_ADDR;
                        end
                        8'h00: begin
                            r_op    <= OP_READ;
                            r_acnt  <= '0;
                            r_state <= S_ADDR;
                        end
                        8'h80: begin
                            r_op    <= OP_PROG;
                            r_acnt  <= '0;
                            r_mask  <= '0;
                            r_state <= S_ADDR;
                        end
                        8'h30: begin
                            if (r_state == S_WAIT_CONF) begin
                                r_state <= S_BUSY;
                                r_op    <= OP_READ;
                                r_cnt   <= 16'(T_RD - 1);
                                r_rnb   <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                        8'h10: begin
                            if (r_state == S_DIN) begin
                                r_state <= S_BUSY;
                                r_op    <= OP_PROG;
                                r_cnt   <= 16'(T_PROG - 1);
                                r_rnb   <= 1'b0;
                                r_fail  <= !nf_wpb_i;
                                // A protected page keeps its contents: drop the staged bytes.
                                if (!nf_wpb_i) begin
                                    r_mask <= '0;
                                end
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end else if (w_addr && r_state == S_ADDR) begin
                if (r_op == OP_ID) begin
                    r_sel    <= SEL_ID;
                    r_id_ptr <= '0;
                    r_state  <= S_DOUT;
                end else begin
                    r_col_ptr <= w_col_new;
                    r_acnt    <= r_acnt + 4'd1;
                    if (int'(r_acnt) == c_acyc - 1) begin
                        r_state <= (r_op == OP_READ) ? S_WAIT_CONF : S_DIN;
                    end
                end
            end else if (w_data && r_state == S_DIN) begin
                r_stage[r_col_ptr] <= r_wbyte;
                r_mask[r_col_ptr]  <= 1'b1;
                r_col_ptr          <= r_col_ptr + c_aw'(1);
            end

            if (r_rev && r_state == S_DOUT) begin
                if (r_sel == SEL_PAGE) begin
                    r_col_ptr <= r_col_ptr + c_aw'(1);
                end else if (r_sel == SEL_ID && r_id_ptr < 3'd4) begin
                    r_id_ptr <= r_id_ptr + 3'd1;
                end
            end
        end
    end

    assign dev_dat_o  = r_dout;
    assign dev_dat_oe = r_oe;
    assign nf_rnb_o   = r_rnb;

endmodule
`default_nettype wire
